// File: rtl/ets_pkg.sv
`default_nettype none
// ============================================================================
// ets_pkg : shared sizes and FSM state encoding for the ETS window readout
// Revision: 1.0
// ============================================================================
package ets_pkg;

    localparam int NUM_LANES   = 8;
    localparam int CNT_W       = 32;
    localparam int FRAME_WORDS = NUM_LANES + 1;
    localparam int IDX_W       = 4;

    // Word index of the final (lane 7) word in a frame; index 0 is the header.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_SETTLE = 3'd3,
        S_SNAP   = 3'd4,
        S_STREAM = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ets_snapshot_bank.sv
`default_nettype none
// ============================================================================
// ets_snapshot_bank : captures all adder lanes on a strobe and muxes one frame
//                     word (header or a lane) onto the output.
// Revision: 1.0
// ============================================================================
module ets_snapshot_bank
    import ets_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture,
    input  logic [NUM_LANES*CNT_W-1:0] cnt_in,
    input  logic [CNT_W-1:0]           header,
    input  logic [IDX_W-1:0]           sel,
    output logic [CNT_W-1:0]           word
);

    logic [CNT_W-1:0] r_lane [NUM_LANES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lane[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lane[i] <= cnt_in[i*CNT_W +: CNT_W];
            end
        end
    end

    // Index 0 selects the header, 1..NUM_LANES select lanes 0..NUM_LANES-1.
    always_comb begin
        word = header;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == IDX_W'(i + 1)) begin
                word = r_lane[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ets_window_readout.sv
`default_nettype none
// ============================================================================
// ets_window_readout : gates an 8-lane bit-count adder for a window of samples,
//                      snapshots the lanes and streams header + lanes out.
// Revision: 1.0
// ============================================================================
module ets_window_readout
    import ets_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           window_len,
    input  logic                       sample_valid,
    output logic                       acc_enable,
    output logic                       acc_clr,
    input  logic [NUM_LANES*CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_len_q;
    logic [CNT_W-1:0] r_remaining;
    logic [IDX_W-1:0] r_idx;
    logic             w_capture;
    logic             w_at_last;
    logic             w_xfer;
    logic [CNT_W-1:0] w_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_q     <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_len_q     <= window_len;
                r_remaining <= window_len;
            end else if (r_state == S_ACCUM && sample_valid) begin
                r_remaining <= r_remaining - 1'b1;
            end

            if (r_state != S_STREAM) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= w_at_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign w_at_last = (r_idx == LAST_IDX);
    assign w_xfer    = m_valid & m_ready;

    always_comb begin
        w_state_nxt = r_state;
        acc_enable  = 1'b0;
        acc_clr     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        done        = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clr     = 1'b1;
                w_state_nxt = (r_len_q != '0) ? S_ACCUM : S_SETTLE;
            end
            S_ACCUM: begin
                acc_enable = sample_valid;
                // remaining is never 0 here, so ==1 marks the final sample
                if (sample_valid && r_remaining == CNT_W'(1)) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_SNAP;
            end
            S_SNAP: begin
                acc_clr     = 1'b1;
                w_capture   = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                m_valid = 1'b1;
                m_last  = w_at_last;
                if (m_ready && w_at_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign m_data = m_valid ? w_word : '0;

    ets_snapshot_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .capture (w_capture),
        .cnt_in  (cnt_in),
        .header  (r_len_q),
        .sel     (r_idx),
        .word    (w_word)
    );

endmodule
`default_nettype wire

// File: doc/ets_window_readout.md
ETS_WINDOW_READOUT -- requirements
Module: ets_window_readout

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-003 SHALL have port start  input  1  request a new accumulation window; honoured only in IDLE.
REQ-004 SHALL have port window_len  input  32  number of accepted samples per window; latched on an accepted start.
REQ-005 SHALL have port sample_valid  input  1  upstream per-cycle sample strobe.
REQ-006 SHALL have port acc_enable  output  1  enable to the 8-lane bit-count adder.
REQ-007 SHALL have port acc_clr  output  1  clear to the 8-lane bit-count adder.
REQ-008 SHALL have port cnt_in  input  256  adder counters; lane i at bits [32i+31:32i], i = 0..7.
REQ-009 SHALL have ports m_data output 32, m_valid output 1, m_ready input 1, m_last output 1  result stream.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and done output 1 (one-cycle pulse at frame end).

Function
REQ-011 SHALL implement the states IDLE, CLEAR, ACCUM, SETTLE, SNAP, STREAM, DONE.
REQ-012 IDLE -> CLEAR on start = 1; window_len latched into len_q and the remaining-sample counter in the same cycle.
REQ-013 CLEAR SHALL last exactly 1 cycle with acc_clr = 1; next state ACCUM if len_q != 0, else SETTLE.
REQ-014 In ACCUM, acc_enable SHALL equal sample_valid (combinational); each sample_valid = 1 cycle decrements remaining by 1.
REQ-015 ACCUM -> SETTLE in the cycle after the sample that brings remaining to 0; exactly len_q samples are enabled.
REQ-016 acc_enable SHALL be 0 in every state except ACCUM; sample_valid outside ACCUM is dropped.
REQ-017 SETTLE SHALL last 1 cycle, allowing the adder's registered final update to appear on cnt_in.
REQ-018 SNAP SHALL capture all 8 lanes of cnt_in into a snapshot bank and assert acc_clr for that 1 cycle; next state STREAM.
REQ-019 STREAM SHALL emit 9 words in order: len_q, then lane 0 through lane 7 snapshot values; m_last = 1 only on the lane-7 word.
REQ-020 A word SHALL transfer on m_valid & m_ready; m_data and m_last SHALL hold stable while m_valid & !m_ready.
REQ-021 m_valid SHALL rise in the first STREAM cycle and stay high until the 9th transfer; no bubbles while m_ready = 1.
REQ-022 After the 9th transfer -> DONE; done = 1 for 1 cycle; next state IDLE.
REQ-023 start while busy = 1 SHALL be ignored with no effect on len_q or the current frame.
REQ-024 window_len = 0 SHALL produce a frame of header 0 followed by eight lane words (counters cleared in CLEAR).
REQ-025 window_len = 0xFFFFFFFF SHALL be counted without wrap; remaining is a 32-bit down-counter.
REQ-026 Minimum IDLE-to-first-m_valid latency SHALL be len_q + 4 cycles with sample_valid held at 1.

Reset
REQ-027 While reset = 0 at a clk edge: state IDLE; acc_enable, acc_clr, m_valid, m_last, done, busy = 0; m_data, len_q, remaining, and snapshot bank = 0.
REQ-028 Reset asserted mid-window or mid-stream SHALL abort the frame; no partial-frame continuation after release.
REQ-029 After reset release, the first start SHALL pass through CLEAR, so stale adder counts never reach the stream.

Structure
REQ-030 Shared package ets_pkg SHALL hold NUM_LANES = 8, CNT_W = 32, FRAME_WORDS = NUM_LANES + 1, and the state enumeration.
REQ-031 The capture registers and word-select mux SHALL be one sub-module, ets_snapshot_bank (capture strobe, 3-bit+header index, 32-bit out).
REQ-032 FSM, sample counter and stream handshake SHALL stay in ets_window_readout; target size 120-400 RTL lines total.

Verification
REQ-033 Test: window_len = 5, sample_valid = 1 continuously, adder fed 0xA5 -> frame 5, 5,0,5,0,0,5,0,5 (lanes 0..7); m_last on 9th word; done pulse once.
REQ-034 Test: window_len = 4, sample_valid toggling 1,0 -> exactly 4 acc_enable pulses; ACCUM lasts 8 cycles; header 4.
REQ-035 Test: window_len = 0 -> acc_enable never high; frame 0 followed by eight 0 words; two acc_clr pulses (CLEAR, SNAP).
REQ-036 Test: m_ready low for 3 cycles on word 2 -> m_data/m_last unchanged throughout; the 9 words arrive in order without loss or duplication.
REQ-037 Test: start pulsed during ACCUM and STREAM -> ignored; reset = 0 mid-STREAM -> m_valid 0 next cycle, state IDLE, new start gives a clean frame.
